a5_1_ctrl: RTL

A5_1_CTRL -- requirements
Module: a5_1_ctrl

---
 rtl/a5_1_pkg.sv | 46 ++++
 rtl/a5_1_lfsr.sv | 66 ++++++
 rtl/a5_1_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/a5_1_pkg.sv
// A5/1 keystream controller: shared state codes, LFSR geometry and phase lengths.
// Optional frame auto-increment is enabled by defining A51_FRAME_AUTOINC_EN.
package a5_1_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KEY   = 3'd1,
    S_FRAME = 3'd2,
    S_MIX   = 3'd3,
    S_GEN   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    M_HOLD  = 2'd0,
    M_CLEAR = 2'd1,
    M_LOAD  = 2'd2,
    M_MAJ   = 2'd3
  } mode_t;

  localparam int R1_LEN = 19;
  localparam int R2_LEN = 22;
  localparam int R3_LEN = 23;

  localparam logic [R1_LEN-1:0] R1_TAPS = 19'h72000;
  localparam logic [R2_LEN-1:0] R2_TAPS = 22'h300000;
  localparam logic [R3_LEN-1:0] R3_TAPS = 23'h700080;

  localparam int R1_CLK = 8;
  localparam int R2_CLK = 10;
  localparam int R3_CLK = 10;

  localparam int KEY_CYC   = 64;
  localparam int FRAME_CYC = 22;
  localparam int MIX_CYC   = 100;
  localparam int CNT_W     = 9;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/a5_1_lfsr.sv
// A5/1 register bank: three LFSRs with clear, bit-load and majority-clock modes.
// ks_bit is taken from the post-clock state, as in the reference generator.
module a5_1_lfsr
  import a5_1_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  mode_t mode,
  input  logic  in_bit,
  output logic  ks_bit
);

  logic [R1_LEN-1:0] r1, r1_n;
  logic [R2_LEN-1:0] r2, r2_n;
  logic [R3_LEN-1:0] r3, r3_n;
  logic              fb1, fb2, fb3;
  logic              m;

  assign fb1 = ^(r1 & R1_TAPS);
  assign fb2 = ^(r2 & R2_TAPS);
  assign fb3 = ^(r3 & R3_TAPS);
  assign m   = maj3(r1[R1_CLK], r2[R2_CLK], r3[R3_CLK]);

  always_comb begin
    r1_n = r1;
    r2_n = r2;
    r3_n = r3;
    unique case (mode)
      M_CLEAR: begin
        r1_n = '0;
        r2_n = '0;
        r3_n = '0;
      end
      M_LOAD: begin
        r1_n = {r1[R1_LEN-2:0], fb1 ^ in_bit};
        r2_n = {r2[R2_LEN-2:0], fb2 ^ in_bit};
        r3_n = {r3[R3_LEN-2:0], fb3 ^ in_bit};
      end
      M_MAJ: begin
        if (r1[R1_CLK] == m)
          r1_n = {r1[R1_LEN-2:0], fb1};
        if (r2[R2_CLK] == m)
          r2_n = {r2[R2_LEN-2:0], fb2};
        if (r3[R3_CLK] == m)
          r3_n = {r3[R3_LEN-2:0], fb3};
      end
      default: ;
    endcase
    ks_bit = r1_n[R1_LEN-1]
           ^ r2_n[R2_LEN-1]
           ^ r3_n[R3_LEN-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
    end else begin
      r1 <= r1_n;
      r2 <= r2_n;
      r3 <= r3_n;
    end
  end

endmodule

// File: rtl/a5_1_ctrl.sv
// A5/1 run controller: FSM, phase counter, input latches and msg XOR buffer.
// Define A51_FRAME_AUTOINC_EN to advance the latched frame after every run.
module a5_1_ctrl
  import a5_1_pkg::*;
#(
  parameter int MSG_W = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [63:0]      key,
  input  logic [21:0]      frame,
  input  logic [8:0]       len,
  input  logic [MSG_W-1:0] msg,
  output logic             busy,
  output logic             done,
  output logic [MSG_W-1:0] ans,
  output logic [2:0]       state
);

  localparam logic [CNT_W-1:0] KEY_END = CNT_W'(KEY_CYC - 1);
  localparam logic [CNT_W-1:0] FRM_END = CNT_W'(FRAME_CYC - 1);
  localparam logic [CNT_W-1:0] MIX_END = CNT_W'(MIX_CYC - 1);
  localparam logic [CNT_W-1:0] MSG_L   = CNT_W'(MSG_W);

  state_t             st;
  logic [CNT_W-1:0]   cnt;
  logic [63:0]        key_q;
  logic [21:0]        frame_q;
  logic [MSG_W-1:0]   msg_q;
  logic [CNT_W-1:0]   l_q;
  logic [MSG_W-1:0]   ks_buf;
  logic [MSG_W-1:0]   ks_fin;
  logic [MSG_W-1:0]   mask;
  logic [CNT_W-1:0]   len_eff;
  mode_t              mode;
  logic               in_bit;
  logic               ks_bit;
`ifdef A51_FRAME_AUTOINC_EN
  logic               inc_on;
`endif

  assign state   = st;
  assign len_eff = (len > MSG_L) ? MSG_L : len;

  always_comb begin
    mode   = M_HOLD;
    in_bit = 1'b0;
    unique case (st)
      S_IDLE:  mode = start ? M_CLEAR : M_HOLD;
      S_KEY: begin
        mode   = M_LOAD;
        in_bit = key_q[cnt[5:0]];
      end
      S_FRAME: begin
        mode   = M_LOAD;
        in_bit = frame_q[cnt[4:0]];
      end
      S_MIX:   mode = M_MAJ;
      S_GEN:   mode = M_MAJ;
      default: mode = M_HOLD;
    endcase
  end

  // The last GEN bit is merged here so ans can be formed on the same edge.
  always_comb begin
    ks_fin = ks_buf;
    mask   = '0;
    for (int i = 0; i < MSG_W; i++) begin
      if (st == S_GEN && cnt == CNT_W'(i))
        ks_fin[i] = ks_bit;
      mask[i] = CNT_W'(i) < l_q;
    end
  end

  a5_1_lfsr u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .mode   (mode),
    .in_bit (in_bit),
    .ks_bit (ks_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st      <= S_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ans     <= '0;
      key_q   <= '0;
      frame_q <= '0;
      msg_q   <= '0;
      l_q     <= '0;
      ks_buf  <= '0;
`ifdef A51_FRAME_AUTOINC_EN
      inc_on  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (st)
        S_IDLE: begin
          if (start) begin
            st     <= S_KEY;
            cnt    <= '0;
            busy   <= 1'b1;
            key_q  <= key;
            msg_q  <= msg;
            l_q    <= len_eff;
            ks_buf <= '0;
`ifdef A51_FRAME_AUTOINC_EN
            if (!inc_on)
              frame_q <= frame;
`else
            frame_q <= frame;
`endif
          end
        end
        S_KEY: begin
          if (cnt == KEY_END) begin
            st  <= S_FRAME;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FRAME: begin
          if (cnt == FRM_END) begin
            st  <= S_MIX;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_MIX: begin
          if (cnt == MIX_END) begin
            cnt <= '0;
            if (l_q == '0) begin
              st   <= S_DONE;
              busy <= 1'b0;
              done <= 1'b1;
              ans  <= (msg_q ^ ks_fin) & mask;
            end else begin
              st <= S_GEN;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GEN: begin
          ks_buf <= ks_fin;
          if (cnt == l_q - 1'b1) begin
            st   <= S_DONE;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b1;
            ans  <= (msg_q ^ ks_fin) & mask;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          st  <= S_IDLE;
          cnt <= '0;
`ifdef A51_FRAME_AUTOINC_EN
          frame_q <= frame_q + 22'd1;
          inc_on  <= 1'b1;
`endif
        end
        default: begin
          st  <= S_IDLE;
          cnt <= '0;
        end
      endcase
    end
  end

endmodule
